// File: rtl/proc_io_buf_pkg.sv
// Shared helpers for the buffered processor I/O subsystem.
// Provides the address-width helper and the packed-bus channel slice offset.
package proc_io_buf_pkg;

   // Address width for n channels; a single channel still needs one address bit.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Low bit of channel ch in a bus of w-bit words packed channel 0 at the LSBs.
   function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned w);
      return ch * w;
   endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous first-word-fall-through FIFO for one I/O channel.
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   push, push_data  write request and word; ignored when full unless popping
//   pop              read request; ignored when empty
//   head_c           word at the head (valid while !empty_c)
//   full_c, empty_c  status decoded from the registered occupancy count
module io_fifo #(
   parameter int unsigned NUBITS = 16,
   parameter int unsigned FDEPTH = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [NUBITS-1:0] push_data,
   input  logic              pop,
   output logic [NUBITS-1:0] head_c,
   output logic              full_c,
   output logic              empty_c
);

   localparam int unsigned PW = $clog2(FDEPTH);
   localparam int unsigned CW = PW + 1;

   logic [NUBITS-1:0] mem [FDEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              do_push;
   logic              do_pop;

   assign full_c  = (count == CW'(FDEPTH));
   assign empty_c = (count == '0);
   assign head_c  = mem[rd_ptr];

   // A push into a full FIFO is legal when a pop frees the head slot in the same cycle.
   assign do_pop  = pop & ~empty_c;
   assign do_push = push & (~full_c | do_pop);

   // Pointers and occupancy; pointers wrap naturally since FDEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care once the pointers are reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/proc_io_buf.sv
// Multi-channel buffered I/O between the processor's port-mapped I/O and
// streaming peripherals, with per-channel FIFOs, sticky error flags and a
// maskable data-available interrupt.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_in, addr_in, io_in        processor read strobe, channel, returned word (1-cycle latency)
//   out_en, addr_out, io_out      processor write strobe, channel, written word
//   itr                           registered interrupt: any masked input channel non-empty
//   in_data/in_valid/in_ready     peripheral input streams, channel i at [i*NUBITS +: NUBITS]
//   out_data/out_valid/out_ready  peripheral output streams (first-word-fall-through)
//   err_udf                       sticky: processor read an empty input channel
//   err_ovf                       sticky: processor write dropped on a full output channel
module proc_io_buf
   import proc_io_buf_pkg::*;
#(
   parameter int unsigned       NUBITS = 16,
   parameter int unsigned       NUIOIN = 2,
   parameter int unsigned       NUIOOU = 2,
   parameter int unsigned       FDEPTH = 4,
   parameter logic [NUIOIN-1:0] ITRMSK = {NUIOIN{1'b1}},
   parameter int unsigned       AINW   = clog2_min1(NUIOIN),
   parameter int unsigned       AOUW   = clog2_min1(NUIOOU)
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_in,
   input  logic [AINW-1:0]          addr_in,
   output logic [NUBITS-1:0]        io_in,
   input  logic                     out_en,
   input  logic [AOUW-1:0]          addr_out,
   input  logic [NUBITS-1:0]        io_out,
   output logic                     itr,
   input  logic [NUIOIN*NUBITS-1:0] in_data,
   input  logic [NUIOIN-1:0]        in_valid,
   output logic [NUIOIN-1:0]        in_ready,
   output logic [NUIOOU*NUBITS-1:0] out_data,
   output logic [NUIOOU-1:0]        out_valid,
   input  logic [NUIOOU-1:0]        out_ready,
   output logic [NUIOIN-1:0]        err_udf,
   output logic [NUIOOU-1:0]        err_ovf
);

   logic [NUBITS-1:0] in_head  [NUIOIN];
   logic [NUIOIN-1:0] in_full;
   logic [NUIOIN-1:0] in_empty;
   logic [NUIOIN-1:0] in_push;
   logic [NUIOIN-1:0] in_pop;
   logic [NUIOIN-1:0] rd_sel;
   logic [NUIOIN-1:0] udf_set;
   logic [NUBITS-1:0] rd_word_c;

   logic [NUBITS-1:0] out_head [NUIOOU];
   logic [NUIOOU-1:0] out_full;
   logic [NUIOOU-1:0] out_empty;
   logic [NUIOOU-1:0] out_pop;
   logic [NUIOOU-1:0] wr_sel;
   logic [NUIOOU-1:0] ovf_set;

   // Read-address decode; addresses beyond the last channel select nothing.
   always_comb begin
      rd_sel = '0;
      for (int unsigned i = 0; i < NUIOIN; i++) begin
         if (req_in && (addr_in == AINW'(i))) rd_sel[i] = 1'b1;
      end
   end

   // Word returned to the processor: head of the popped channel, else zero.
   always_comb begin
      rd_word_c = '0;
      for (int unsigned i = 0; i < NUIOIN; i++) begin
         if (in_pop[i]) rd_word_c = in_head[i];
      end
   end

   // Write-address decode; addresses beyond the last channel are ignored.
   always_comb begin
      wr_sel = '0;
      for (int unsigned j = 0; j < NUIOOU; j++) begin
         if (out_en && (addr_out == AOUW'(j))) wr_sel[j] = 1'b1;
      end
   end

   // Readiness comes from registered occupancy only, so a full channel refuses
   // a push even when the processor pops it in the same cycle. Occupancy is
   // sampled before the push lands, so a same-cycle read of an empty channel
   // still underflows.
   assign in_ready = ~in_full;
   assign in_push  = in_valid & ~in_full;
   assign in_pop   = rd_sel & ~in_empty;
   assign udf_set  = rd_sel & in_empty;

   // Valid is withheld during reset so no peripheral handshake happens on a flushing cycle.
   assign out_valid = ~out_empty & {NUIOOU{~rst}};
   assign out_pop   = out_valid & out_ready;
   assign ovf_set   = wr_sel & out_full & ~out_pop;

   for (genvar i = 0; i < NUIOIN; i++) begin : g_in
      io_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (in_push[i]),
         .push_data (in_data[slice_lo(i, NUBITS) +: NUBITS]),
         .pop       (in_pop[i]),
         .head_c    (in_head[i]),
         .full_c    (in_full[i]),
         .empty_c   (in_empty[i])
      );
   end

   for (genvar j = 0; j < NUIOOU; j++) begin : g_out
      io_fifo #(.NUBITS(NUBITS), .FDEPTH(FDEPTH)) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (wr_sel[j]),
         .push_data (io_out),
         .pop       (out_pop[j]),
         .head_c    (out_head[j]),
         .full_c    (out_full[j]),
         .empty_c   (out_empty[j])
      );
      assign out_data[slice_lo(j, NUBITS) +: NUBITS] = out_head[j];
   end

   // Processor read register, sticky error flags and interrupt level.
   always_ff @(posedge clk) begin
      if (rst) begin
         io_in   <= '0;
         itr     <= 1'b0;
         err_udf <= '0;
         err_ovf <= '0;
      end else begin
         if (req_in) io_in <= rd_word_c;
         itr     <= |(~in_empty & ITRMSK);
         err_udf <= err_udf | udf_set;
         err_ovf <= err_ovf | ovf_set;
      end
   end

endmodule
